mux_channel_scanner: RTL and testbench

Sequential select generator and sample collector for the 8-to-1 multiplexer stage. On a start request it steps the mux select lines through channels 0..7 and waits a programmable settle time on each channel. It then samples the mux output Y and packs the eight samples into a byte. It drives the mux selects (upstream of the mux) and consumes Y (downstream of the mux), so a single mux can serve as a serial 8-bit input port.

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/scan_settle_timer.sv | 28 ++
 rtl/mux_channel_scanner.sv | 92 +++++++++
 tb/tb_mux_channel_scanner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the 8-channel mux scanner.
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// Settle-time down-counter: load arms it, expired is high once the count reaches zero.
module scan_settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles before expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps an 8:1 mux through all channels, samples Y after a settle time and packs a byte.
module mux_channel_scanner
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       y_in,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [NUM_CH-1:0]   shadow;
    logic                load;
    logic                expired;

    // Timer restarts on every entry into SETTLE; busy at the last SAMPLE means continuous rescan.
    assign load = (state == IDLE && start) ||
                  (state == SAMPLE && (ch != LAST_CH || busy));

    scan_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ch     <= '0;
            shadow <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            data   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETTLE;
                        ch    <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (expired) begin
                        shadow[ch] <= y_in;
                        state      <= SAMPLE;
                        // Byte is published only once the final channel is captured.
                        if (ch == LAST_CH) begin
                            data <= {y_in, shadow[NUM_CH-2:0]};
                            done <= 1'b1;
                            busy <= continuous;
                        end
                    end
                end
                SAMPLE: begin
                    if (ch != LAST_CH) begin
                        ch    <= ch + CH_W'(1);
                        state <= SETTLE;
                    end else if (busy) begin
                        ch    <= '0;
                        state <= SETTLE;
                    end else begin
                        ch    <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {s0, s1, s2} = ch;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed and randomized bench for mux_channel_scanner with a cycle-position reference model.
module tb_mux_channel_scanner;

    localparam int S    = 2;
    localparam int SCAN = 8 * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic       y_in;
    logic       s0, s1, s2;
    logic       busy;
    logic       done;
    logic [7:0] data;

    logic [7:0] mux_in;
    logic       noise_en;
    logic       noise_val;
    logic [7:0] exp_data;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Behavioural 8:1 mux; noise overrides Y outside the capture window.
    assign y_in = noise_en ? noise_val : mux_in[{s0, s1, s2}];

    mux_channel_scanner #(
        .SETTLE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .continuous(continuous),
        .y_in      (y_in),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .busy      (busy),
        .done      (done),
        .data      (data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_sel"}, {5'b0, s0, s1, s2}, 8'h00);
        checkOutput({tag, "_busy"}, {7'b0, busy}, 8'h00);
        checkOutput({tag, "_done"}, {7'b0, done}, 8'h00);
        checkOutput({tag, "_data"}, data, exp_data);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered at cycle 0 of a scan (just after E0); returns one cycle after the done edge.
    task automatic applyStimulus(input bit cont, input bit noisy, input bit extra_starts,
                                 input logic [7:0] pat_b, input int change_at);
        logic [7:0] scan_exp;
        int k;
        int ph;
        scan_exp   = 8'h00;
        continuous = cont;
        for (int j = 0; j < SCAN; j++) begin
            k  = j / (S + 1);
            ph = j % (S + 1);
            checkOutput("sel", {5'b0, s0, s1, s2}, 8'(k));
            if (j == SCAN - 1) begin
                checkOutput("done_pulse", {7'b0, done}, 8'h01);
                checkOutput("busy_end", {7'b0, busy}, {7'b0, cont});
                checkOutput("data_byte", data, scan_exp);
                exp_data = scan_exp;
            end else begin
                checkOutput("done_quiet", {7'b0, done}, 8'h00);
                checkOutput("busy_scan", {7'b0, busy}, 8'h01);
                checkOutput("data_hold", data, exp_data);
            end
            start = extra_starts && (j == 5 || j == 12);
            if (j == change_at) mux_in = pat_b;
            if (ph == S - 1) begin
                noise_en    = 1'b0;
                scan_exp[k] = mux_in[k];
            end else begin
                noise_en  = noisy;
                noise_val = 1'($urandom_range(0, 1));
            end
            step();
        end
        start    = 1'b0;
        noise_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        mux_in     = 8'h00;
        noise_en   = 1'b0;
        noise_val  = 1'b0;
        exp_data   = 8'h00;

        repeat (3) step();
        checkIdle("reset");
        rst = 1'b0;
        step();
        checkIdle("post_reset");

        $display("[TB] basic scan A5");
        mux_in = 8'hA5;
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, -1);
        checkOutput("basic_byte", data, 8'hA5);
        step();
        checkIdle("basic_idle");

        $display("[TB] random byte with noisy settle window");
        mux_in = 8'($urandom);
        pulseStart();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, -1);
        step();
        checkIdle("noisy_idle");

        $display("[TB] start pulses during scan");
        mux_in = 8'($urandom);
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, -1);
        step();
        checkIdle("ignored_start_idle");

        $display("[TB] continuous mode with mid-scan input change");
        mux_in = 8'hA5;
        pulseStart();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, -1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 12);
        checkOutput("cont_mixed", data, 8'h35);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, -1);
        step();
        checkIdle("cont_idle");

        $display("[TB] asynchronous reset mid-scan");
        mux_in = 8'($urandom);
        pulseStart();
        repeat (10) step();
        #2;
        rst = 1'b1;
        #1;
        exp_data = 8'h00;
        checkIdle("async_reset");
        step();
        step();
        rst = 1'b0;
        step();
        checkIdle("after_release");
        mux_in = 8'($urandom);
        pulseStart();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, -1);
        step();
        checkIdle("recovered_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
